// File: rtl/memory_game_pkg.sv
// Shared types and constants for the 4x4 pairs-game turn sequencer.
// The card index is row*4+col, which is the same as concatenating the two 2-bit coordinates.
package memory_game_pkg;

    typedef enum logic [2:0] {
        WAIT_FIRST,
        WAIT_SECOND,
        SHOW,
        RESOLVE,
        DONE
    } mg_state_t;

    localparam int GRID_DIM  = 4;
    localparam int NUM_CARDS = GRID_DIM * GRID_DIM;
    localparam int NUM_PAIRS = NUM_CARDS / 2;
    localparam int SYM_W     = 3;

    function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/mg_down_timer.sv
// Loadable down counter that stops at zero; zero is high whenever the count is zero.
// Load has priority over the enable.
module mg_down_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: clocked state is always written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/memory_game_ctrl.sv
// Turn sequencer for the 4x4 pairs game: takes two card picks, shows them for a window,
// then retires a matching pair or passes the turn, with an optional per-turn idle timeout.
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES  = 50_000_000,
    parameter int unsigned TURN_TIMEOUT = 500_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel_valid,
    input  logic [1:0]           sel_row,
    input  logic [1:0]           sel_col,
    output logic [1:0]           brd_row,
    output logic [1:0]           brd_col,
    input  logic [SYM_W-1:0]     brd_sym,
    output logic                 sel_ack,
    output logic [NUM_CARDS-1:0] revealed,
    output logic [NUM_CARDS-1:0] matched,
    output logic                 player,
    output logic [3:0]           score0,
    output logic [3:0]           score1,
    output logic                 game_over
);

    localparam int TW = 32;
    // Timers are loaded with N-1 and acted on at zero, so the window spans exactly N cycles.
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LOAD = (TURN_TIMEOUT > 0) ? TW'(TURN_TIMEOUT - 1) : '0;
    localparam logic [3:0]    SCORE_MAX = 4'(NUM_PAIRS);

    mg_state_t            r_state;
    logic [3:0]           r_idx1, r_idx2;
    logic [SYM_W-1:0]     r_sym1, r_sym2;
    logic [NUM_CARDS-1:0] r_revealed, r_matched;
    logic                 r_player, r_sel_ack, r_game_over, r_turn_armed;
    logic [3:0]           r_score0, r_score1, r_pairs;

    logic [3:0] w_idx, w_pairs_next;
    logic       w_wait, w_accept, w_timeout, w_match;
    logic       w_show_zero, w_turn_zero, w_show_load, w_turn_load;

    assign w_idx        = idx(sel_row, sel_col);
    assign w_wait       = (r_state == WAIT_FIRST) || (r_state == WAIT_SECOND);
    assign w_accept     = w_wait && sel_valid && !r_matched[w_idx] && !r_revealed[w_idx];
    assign w_timeout    = (TURN_TIMEOUT != 0) && r_turn_armed && w_wait && w_turn_zero && !w_accept;
    assign w_match      = (r_sym1 == r_sym2);
    assign w_pairs_next = r_pairs + 4'd1;
    assign w_show_load  = w_accept && (r_state == WAIT_SECOND);
    // Turn timer restarts on each accept and on every way back into WAIT_FIRST.
    assign w_turn_load  = w_accept || w_timeout || !r_turn_armed || (r_state == RESOLVE);

    mg_down_timer #(.WIDTH(TW)) u_show_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_show_load),
        .value (SHOW_LOAD),
        .en    (r_state == SHOW),
        .zero  (w_show_zero)
    );

    mg_down_timer #(.WIDTH(TW)) u_turn_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_turn_load),
        .value (TURN_LOAD),
        .en    (w_wait),
        .zero  (w_turn_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= WAIT_FIRST;
            r_idx1       <= '0;
            r_idx2       <= '0;
            r_sym1       <= '0;
            r_sym2       <= '0;
            r_revealed   <= '0;
            r_matched    <= '0;
            r_player     <= 1'b0;
            r_sel_ack    <= 1'b0;
            r_game_over  <= 1'b0;
            r_turn_armed <= 1'b0;
            r_score0     <= '0;
            r_score1     <= '0;
            r_pairs      <= '0;
        end else begin
            r_turn_armed <= 1'b1;
            r_sel_ack    <= w_accept;
            case (r_state)
                WAIT_FIRST: begin
                    if (w_accept) begin
                        r_idx1            <= w_idx;
                        r_sym1            <= brd_sym;
                        r_revealed[w_idx] <= 1'b1;
                        r_state           <= WAIT_SECOND;
                    end else if (w_timeout) begin
                        r_revealed <= '0;
                        r_player   <= ~r_player;
                    end
                end
                WAIT_SECOND: begin
                    if (w_accept) begin
                        r_idx2            <= w_idx;
                        r_sym2            <= brd_sym;
                        r_revealed[w_idx] <= 1'b1;
                        r_state           <= SHOW;
                    end else if (w_timeout) begin
                        r_revealed <= '0;
                        r_player   <= ~r_player;
                        r_state    <= WAIT_FIRST;
                    end
                end
                SHOW: begin
                    if (w_show_zero) r_state <= RESOLVE;
                end
                RESOLVE: begin
                    r_revealed[r_idx1] <= 1'b0;
                    r_revealed[r_idx2] <= 1'b0;
                    r_state            <= WAIT_FIRST;
                    if (w_match) begin
                        r_matched[r_idx1] <= 1'b1;
                        r_matched[r_idx2] <= 1'b1;
                        r_pairs           <= w_pairs_next;
                        if (!r_player && (r_score0 != SCORE_MAX)) r_score0 <= r_score0 + 4'd1;
                        if (r_player && (r_score1 != SCORE_MAX))  r_score1 <= r_score1 + 4'd1;
                        if (w_pairs_next == 4'(NUM_PAIRS)) begin
                            r_state     <= DONE;
                            r_game_over <= 1'b1;
                        end
                    end else begin
                        r_player <= ~r_player;
                    end
                end
                DONE: r_game_over <= 1'b1;
                default: r_state <= WAIT_FIRST;
            endcase
        end
    end

    assign brd_row   = sel_row;
    assign brd_col   = sel_col;
    assign sel_ack   = r_sel_ack;
    assign revealed  = r_revealed;
    assign matched   = r_matched;
    assign player    = r_player;
    assign score0    = r_score0;
    assign score1    = r_score1;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: match, mismatch, rejects, timeout, reset mid-SHOW, full game.
// A small behavioural board supplies symbols; all expected values are hand-computed constants.
module tb_memory_game_ctrl;

    localparam int SHOW_CYCLES  = 4;
    localparam int TURN_TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel_valid = 1'b0;
    logic [1:0]  sel_row = '0, sel_col = '0;
    logic [1:0]  brd_row, brd_col;
    logic [2:0]  brd_sym;
    logic        sel_ack, player, game_over;
    logic [15:0] revealed, matched;
    logic [3:0]  score0, score1;

    logic [2:0]  board [16];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign brd_sym = board[{brd_row, brd_col}];

    memory_game_ctrl #(
        .SHOW_CYCLES  (SHOW_CYCLES),
        .TURN_TIMEOUT (TURN_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel_valid (sel_valid),
        .sel_row   (sel_row),
        .sel_col   (sel_col),
        .brd_row   (brd_row),
        .brd_col   (brd_col),
        .brd_sym   (brd_sym),
        .sel_ack   (sel_ack),
        .revealed  (revealed),
        .matched   (matched),
        .player    (player),
        .score0    (score0),
        .score1    (score1),
        .game_over (game_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic select(input logic [1:0] r, input logic [1:0] c);
        sel_row   = r;
        sel_col   = c;
        sel_valid = 1'b1;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cycles(1);
        reset = 1'b1;
    endtask

    // Two accepted picks followed by the SHOW window and the RESOLVE cycle.
    task automatic play_pair(input string tag, input logic [1:0] r1, input logic [1:0] c1,
                             input logic [1:0] r2, input logic [1:0] c2);
        select(r1, c1);
        check({tag, "_ack1"}, sel_ack, 1);
        select(r2, c2);
        check({tag, "_ack2"}, sel_ack, 1);
        wait_cycles(SHOW_CYCLES + 2);
    endtask

    initial begin
        // Each symbol appears at exactly two positions.
        board = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7,
                  3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};

        wait_cycles(2);
        reset = 1'b1;
        check("rst_revealed", revealed, 0);
        check("rst_matched", matched, 0);
        check("rst_player", player, 0);
        check("rst_score0", score0, 0);
        check("rst_score1", score1, 0);
        check("rst_game_over", game_over, 0);
        check("rst_sel_ack", sel_ack, 0);
        sel_row = 2'd2;
        sel_col = 2'd3;
        #1;
        check("brd_row_pass", brd_row, 2);
        check("brd_col_pass", brd_col, 3);

        // Match: (0,1) and (3,3) both carry symbol 3.
        select(2'd0, 2'd1);
        check("m_ack1", sel_ack, 1);
        check("m_rev1", revealed, 16'h0002);
        wait_cycles(1);
        check("m_ack_pulse", sel_ack, 0);
        select(2'd0, 2'd1);
        check("rej_same_ack", sel_ack, 0);
        check("rej_same_rev", revealed, 16'h0002);
        select(2'd3, 2'd3);
        check("m_ack2", sel_ack, 1);
        check("m_rev2", revealed, 16'h8002);
        select(2'd1, 2'd0);
        check("rej_show_ack", sel_ack, 0);
        check("rej_show_rev", revealed, 16'h8002);
        wait_cycles(2);
        check("m_show_hold", revealed, 16'h8002);
        check("m_show_matched", matched, 0);
        wait_cycles(3);
        check("m_res_rev", revealed, 0);
        check("m_res_matched", matched, 16'h8002);
        check("m_res_score0", score0, 1);
        check("m_res_player", player, 0);

        // Matched card cannot be picked again.
        select(2'd0, 2'd1);
        check("rej_matched_ack", sel_ack, 0);
        check("rej_matched_rev", revealed, 0);

        // Mismatch: (0,0) sym 0 vs (0,2) sym 1, with a repeated pick rejected in between.
        select(2'd0, 2'd0);
        check("mm_ack1", sel_ack, 1);
        select(2'd0, 2'd0);
        check("rej_twice_ack", sel_ack, 0);
        select(2'd0, 2'd2);
        check("mm_ack2", sel_ack, 1);
        check("mm_rev", revealed, 16'h0005);
        wait_cycles(SHOW_CYCLES + 2);
        check("mm_res_rev", revealed, 0);
        check("mm_res_matched", matched, 16'h8002);
        check("mm_res_player", player, 1);
        check("mm_res_score0", score0, 1);

        // Timeout: one card up, then no input.
        select(2'd1, 2'd0);
        check("to_ack", sel_ack, 1);
        check("to_rev", revealed, 16'h0010);
        wait_cycles(TURN_TIMEOUT - 2);
        check("to_before_rev", revealed, 16'h0010);
        check("to_before_player", player, 1);
        wait_cycles(3);
        check("to_after_rev", revealed, 0);
        check("to_after_player", player, 0);
        select(2'd1, 2'd0);
        check("to_wf_accept", sel_ack, 1);
        select(2'd2, 2'd3);
        check("to_ws_accept", sel_ack, 1);

        // Reset while in SHOW.
        wait_cycles(1);
        do_reset();
        check("rm_revealed", revealed, 0);
        check("rm_matched", matched, 0);
        check("rm_score0", score0, 0);
        check("rm_player", player, 0);
        check("rm_sel_ack", sel_ack, 0);

        // Full game: player 1 wins two pairs, player 0 the other six.
        play_pair("g_s0", 2'd0, 2'd0, 2'd2, 2'd0);
        check("g_s0_score0", score0, 1);
        play_pair("g_mm1", 2'd0, 2'd1, 2'd0, 2'd2);
        check("g_mm1_player", player, 1);
        play_pair("g_s3", 2'd0, 2'd1, 2'd3, 2'd3);
        play_pair("g_s1", 2'd0, 2'd2, 2'd2, 2'd1);
        check("g_p1_score1", score1, 2);
        check("g_p1_player", player, 1);
        play_pair("g_mm2", 2'd0, 2'd3, 2'd1, 2'd0);
        check("g_mm2_player", player, 0);
        play_pair("g_s2", 2'd0, 2'd3, 2'd2, 2'd2);
        play_pair("g_s4", 2'd1, 2'd0, 2'd2, 2'd3);
        play_pair("g_s5", 2'd1, 2'd1, 2'd3, 2'd0);
        play_pair("g_s6", 2'd1, 2'd2, 2'd3, 2'd1);
        check("g_pre_over", game_over, 0);
        play_pair("g_s7", 2'd1, 2'd3, 2'd3, 2'd2);
        check("g_over", game_over, 1);
        check("g_score0", score0, 6);
        check("g_score1", score1, 2);
        check("g_matched", matched, 16'hFFFF);
        check("g_revealed", revealed, 0);

        // Selections after game over are ignored, even past the turn timeout.
        select(2'd0, 2'd0);
        check("done_ack", sel_ack, 0);
        wait_cycles(TURN_TIMEOUT + 5);
        check("done_over", game_over, 1);
        check("done_player", player, 0);
        check("done_score0", score0, 6);
        check("done_revealed", revealed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
